alarm_annunciator: RTL and testbench

- Downstream consumer of the master controller's 3-bit alarms bus {fire, intrusion (door|window), rain}.
- Latches each alarm, arbitrates by priority, and drives a cadenced buzzer.
- Escalates unacknowledged alarms after a timeout.
- Queues alarm-onset events into a small FIFO for a notification/logging stage over a valid/ready handshake.

---
 rtl/alarm_annunciator_if.sv | 10 +
 rtl/alarm_annunciator.sv | 169 ++++++++++++++++
 tb/tb_alarm_annunciator.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_annunciator_if.sv
// Event stream from the annunciator to a notification/logging consumer.
// valid/ready handshake carrying the 2-bit alarm code at the queue head.
interface alarm_annunciator_if;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/alarm_annunciator.sv
// Alarm latch, priority arbiter, cadenced buzzer, escalation FSM, event FIFO.
// Optional ANNUNC_RAIN_AUTOCLR_EN: rain self-clears and never escalates.
module alarm_annunciator #(
    parameter int TICK_DIV   = 4,
    parameter int ESC_TICKS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           alarms,
    input  logic                 ack,
    output logic                 buzzer,
    output logic [1:0]           active_code,
    output logic                 escalate,
    output logic [2:0]           pending,
    output logic                 overflow,
    alarm_annunciator_if.master  evt
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int EW = $clog2(ESC_TICKS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ALERT, ESCALATE} state_t;

    function automatic logic [1:0] prio(input logic [2:0] v);
        priority case (1'b1)
            v[2]:    prio = 2'd3;
            v[1]:    prio = 2'd2;
            v[0]:    prio = 2'd1;
            default: prio = 2'd0;
        endcase
    endfunction

    state_t          state, state_n;
    logic [EW-1:0]   esc_cnt, esc_n;
    logic [PW-1:0]   prescaler;
    logic [1:0]      cadence, cad_n;
    logic            tick, esc_ok, buzzer_n;
    logic [2:0]      alarms_q, muted, rise, live;
    logic [2:0]      pending_n, muted_n;
    logic [1:0]      code_n;
    logic            push_q, push_ok, pop, full;
    logic [1:0]      push_code_q;
    logic [1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    assign rise     = alarms & ~alarms_q;
    assign live     = pending & ~muted;
    assign tick     = (prescaler == PW'(TICK_DIV - 1));
    assign cad_n    = cadence + {1'b0, tick};
    assign escalate = (state == ESCALATE);

`ifdef ANNUNC_RAIN_AUTOCLR_EN
    assign esc_ok = (live[2:1] != 2'b00);
`else
    assign esc_ok = 1'b1;
`endif

    // A rise beats a simultaneous ack; ack drops gone alarms, mutes live ones.
    always_comb begin
        pending_n = pending;
        muted_n   = muted;
        for (int i = 0; i < 3; i++) begin
            if (rise[i]) begin
                pending_n[i] = 1'b1;
                muted_n[i]   = 1'b0;
            end else if (!alarms[i]) begin
                muted_n[i] = 1'b0;
                if (ack) pending_n[i] = 1'b0;
            end else if (ack) begin
                muted_n[i] = 1'b1;
            end
        end
`ifdef ANNUNC_RAIN_AUTOCLR_EN
        if (!alarms[0]) pending_n[0] = 1'b0;
`endif
    end

    assign code_n = prio(pending_n & ~muted_n);

    always_comb begin
        state_n  = state;
        esc_n    = esc_cnt;
        buzzer_n = 1'b0;
        case (state)
            IDLE: begin
                if (live != 3'b000) begin
                    state_n = ALERT;
                    esc_n   = '0;
                end
            end
            ALERT: begin
                if (live == 3'b000) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (esc_cnt == EW'(ESC_TICKS - 1)) begin
                        if (esc_ok) state_n = ESCALATE;
                    end else begin
                        esc_n = esc_cnt + EW'(1);
                    end
                end
            end
            ESCALATE: begin
                if (live == 3'b000) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        case (state_n)
            ESCALATE: buzzer_n = 1'b1;
            ALERT: begin
                case (code_n)
                    2'd3:    buzzer_n = 1'b1;
                    2'd2:    buzzer_n = ~cad_n[0];
                    2'd1:    buzzer_n = (cad_n == 2'd0);
                    default: buzzer_n = 1'b0;
                endcase
            end
            default: buzzer_n = 1'b0;
        endcase
    end

    assign full          = (count == CW'(FIFO_DEPTH));
    assign evt.evt_valid = (count != '0);
    assign evt.evt_code  = (count != '0) ? mem[rd_ptr] : 2'd0;
    assign pop           = (count != '0) && evt.evt_ready;
    assign push_ok       = push_q && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            esc_cnt     <= '0;
            prescaler   <= '0;
            cadence     <= 2'd0;
            alarms_q    <= 3'b000;
            pending     <= 3'b000;
            muted       <= 3'b000;
            active_code <= 2'd0;
            buzzer      <= 1'b0;
            push_q      <= 1'b0;
            push_code_q <= 2'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            esc_cnt     <= esc_n;
            prescaler   <= tick ? '0 : prescaler + PW'(1);
            cadence     <= cad_n;
            alarms_q    <= alarms;
            pending     <= pending_n;
            muted       <= muted_n;
            active_code <= code_n;
            buzzer      <= buzzer_n;
            push_q      <= (rise != 3'b000);
            push_code_q <= prio(rise);
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
            if (push_q && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_code_q;
    end
endmodule

// File: tb/tb_alarm_annunciator.sv
// Randomized and directed checks of alarm_annunciator against a
// queue-based behavioural model derived from the alarm rules.
module tb_alarm_annunciator;
    localparam int TD = 4;
    localparam int ET = 8;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] alarms;
    logic       ack;
    logic       buzzer, escalate, overflow;
    logic [1:0] active_code;
    logic [2:0] pending;
    int         checks = 0;
    int         passed = 0;

    alarm_annunciator_if evt();

    alarm_annunciator #(.TICK_DIV(TD), .ESC_TICKS(ET), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .alarms(alarms), .ack(ack),
        .buzzer(buzzer), .active_code(active_code), .escalate(escalate),
        .pending(pending), .overflow(overflow), .evt(evt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // Behavioural model: time since reset, tick count since alert, event queue
    logic [2:0] m_aq, m_pend, m_mute;
    int         m_code, m_state, m_ticks, m_cyc, m_pc;
    bit         m_buz, m_ovf, m_pv;
    int         q[$];

    function automatic int prio(input logic [2:0] v);
        if (v[2]) return 3;
        if (v[1]) return 2;
        if (v[0]) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_aq = 0; m_pend = 0; m_mute = 0;
        m_code = 0; m_state = 0; m_ticks = 0; m_cyc = 0; m_pc = 0;
        m_buz = 0; m_ovf = 0; m_pv = 0;
        q.delete();
    endtask

    task automatic model_update();
        logic [2:0] rise, live, np, nm, nlive;
        bit tick, esc_ok, pop;
        int nstate, ncad, ncode, sz;
        rise = alarms & ~m_aq;
        live = m_pend & ~m_mute;
        tick = ((m_cyc % TD) == TD - 1);
        np = m_pend;
        nm = m_mute;
        for (int i = 0; i < 3; i++) begin
            if (rise[i]) begin
                np[i] = 1; nm[i] = 0;
            end else begin
                if (ack && !alarms[i]) np[i] = 0;
                if (!alarms[i]) nm[i] = 0;
                else if (ack) nm[i] = 1;
            end
        end
`ifdef ANNUNC_RAIN_AUTOCLR_EN
        if (!alarms[0]) np[0] = 0;
        esc_ok = (live[2:1] != 0);
`else
        esc_ok = 1;
`endif
        nlive = np & ~nm;
        ncode = prio(nlive);
        nstate = m_state;
        if (m_state == 0) begin
            if (live != 0) begin nstate = 1; m_ticks = 0; end
        end else if (m_state == 1) begin
            if (live == 0) nstate = 0;
            else if (tick) begin
                m_ticks++;
                if (m_ticks >= ET && esc_ok) nstate = 2;
            end
        end else if (live == 0) nstate = 0;
        ncad = ((m_cyc + 1) / TD) % 4;
        if (nstate == 2) m_buz = 1;
        else if (nstate == 1)
            m_buz = (ncode == 3) || (ncode == 2 && ncad % 2 == 0) ||
                    (ncode == 1 && ncad == 0);
        else m_buz = 0;
        sz = q.size();
        pop = (sz != 0) && evt.evt_ready;
        if (pop) void'(q.pop_front());
        if (m_pv) begin
            if (sz == FD && !pop) m_ovf = 1;
            else q.push_back(m_pc);
        end
        m_pv = (rise != 0);
        m_pc = prio(rise);
        m_aq = alarms; m_pend = np; m_mute = nm;
        m_code = ncode; m_state = nstate; m_cyc++;
    endtask

    function automatic logic [10:0] dut_vec();
        return {buzzer, active_code, escalate, pending,
                evt.evt_valid, evt.evt_code, overflow};
    endfunction

    function automatic logic [10:0] mod_vec();
        logic [1:0] hc;
        hc = (q.size() != 0) ? 2'(q[0]) : 2'd0;
        return {m_buz, 2'(m_code), m_state == 2, m_pend,
                q.size() != 0, hc, m_ovf};
    endfunction

    task automatic step(input logic [2:0] a, input bit k, input bit r);
        alarms = a; ack = k; evt.evt_ready = r;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        alarms = 0; ack = 0; evt.evt_ready = 0;
        reset = 1'b1;
        #3;
        checks++;
        if (dut_vec() !== 11'd0)
            $display("FAIL reset_outputs got %h want 000", dut_vec());
        else passed++;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fire();
        do_reset();
        for (int i = 0; i < 5; i++) step(3'b000, 0, 0);
        step(3'b100, 0, 0);
        checks++;
        if ({pending, active_code} !== 5'b100_11)
            $display("FAIL fire_latch got %b want 10011", {pending, active_code});
        else passed++;
        step(3'b100, 0, 0);
        checks++;
        if ({evt.evt_valid, evt.evt_code} !== 3'b1_11)
            $display("FAIL fire_event got %b want 111", {evt.evt_valid, evt.evt_code});
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step(3'b100, 0, 0);
            checks++;
            if (buzzer !== 1'b1) $display("FAIL fire_buzzer got %b want 1", buzzer);
            else passed++;
        end
        step(3'b100, 0, 1);
        checks++;
        if (evt.evt_valid !== 1'b0)
            $display("FAIL fire_pop got %b want 0", evt.evt_valid);
        else passed++;
        checks++;
        if (dut_vec() !== mod_vec())
            $display("FAIL fire_model got %h want %h", dut_vec(), mod_vec());
        else passed++;
    endtask

    task automatic test_escalate();
        int toggles;
        logic prev;
        do_reset();
        toggles = 0;
        prev = 0;
        for (int i = 0; i < 45; i++) begin
            step(3'b010, 0, 0);
            if (!escalate && buzzer !== prev) toggles++;
            prev = buzzer;
            checks++;
            if (dut_vec() !== mod_vec())
                $display("FAIL esc_cyc%0d got %h want %h", i, dut_vec(), mod_vec());
            else passed++;
        end
        checks++;
        if ({escalate, buzzer} !== 2'b11)
            $display("FAIL esc_reached got %b want 11", {escalate, buzzer});
        else passed++;
        checks++;
        if (toggles < 6) $display("FAIL esc_cadence got %0d want >=6", toggles);
        else passed++;
        step(3'b010, 1, 0);
        step(3'b010, 0, 0);
        checks++;
        if ({escalate, buzzer, pending} !== 5'b00_010)
            $display("FAIL esc_ack got %b want 00010", {escalate, buzzer, pending});
        else passed++;
    endtask

    task automatic test_multi();
        do_reset();
        step(3'b000, 0, 0);
        step(3'b111, 0, 0);
        checks++;
        if ({pending, active_code} !== 5'b111_11)
            $display("FAIL multi_latch got %b want 11111", {pending, active_code});
        else passed++;
        step(3'b111, 0, 0);
        checks++;
        if ({evt.evt_valid, evt.evt_code} !== 3'b1_11)
            $display("FAIL multi_event got %b want 111", {evt.evt_valid, evt.evt_code});
        else passed++;
        step(3'b111, 0, 1);
        checks++;
        if (evt.evt_valid !== 1'b0)
            $display("FAIL multi_single got %b want 0", evt.evt_valid);
        else passed++;
        step(3'b011, 1, 0);
        checks++;
        if ({pending, active_code} !== 5'b011_00)
            $display("FAIL multi_ack got %b want 01100", {pending, active_code});
        else passed++;
        step(3'b011, 0, 0);
        checks++;
        if (dut_vec() !== mod_vec() || buzzer !== 1'b0)
            $display("FAIL multi_quiet got %h want %h", dut_vec(), mod_vec());
        else passed++;
    endtask

    task automatic test_overflow();
        int seen;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(3'b001, 0, 0);
            step(3'b000, 0, 0);
        end
        checks++;
        if ({overflow, evt.evt_valid, evt.evt_code} !== 4'b1_1_01)
            $display("FAIL ovf_set got %b want 1101",
                     {overflow, evt.evt_valid, evt.evt_code});
        else passed++;
        step(3'b001, 0, 0);
        step(3'b001, 0, 1);
        checks++;
        if (dut_vec() !== mod_vec())
            $display("FAIL ovf_pushpop got %h want %h", dut_vec(), mod_vec());
        else passed++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (evt.evt_valid) seen++;
            step(3'b000, 0, 1);
        end
        checks++;
        if (seen !== 4) $display("FAIL ovf_drain got %0d want 4", seen);
        else passed++;
        checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        n = 0;
        while (!escalate && n < 80) begin
            step(3'b010, 0, 0);
            n++;
        end
        checks++;
        if (escalate !== 1'b1) $display("FAIL mid_reach got %b want 1", escalate);
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 11'd0)
            $display("FAIL mid_async got %h want 000", dut_vec());
        else passed++;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(3'b010, 0, 0);
        checks++;
        if (pending !== 3'b010) $display("FAIL mid_reannounce got %b want 010", pending);
        else passed++;
        step(3'b010, 0, 0);
        checks++;
        if ({evt.evt_valid, evt.evt_code} !== 3'b1_10)
            $display("FAIL mid_event got %b want 110", {evt.evt_valid, evt.evt_code});
        else passed++;
    endtask

    task automatic test_random();
        logic [2:0] a;
        bit k, r;
        do_reset();
        a = 0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 9) == 0) a[b] = ~a[b];
            k = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 3) == 0);
            step(a, k, r);
            checks++;
            if (dut_vec() !== mod_vec())
                $display("FAIL rand_cyc%0d got %h want %h", i, dut_vec(), mod_vec());
            else passed++;
        end
    endtask

    task automatic test_rain();
        bit esc_seen;
        do_reset();
        esc_seen = 0;
        for (int i = 0; i < 45; i++) begin
            step(3'b001, 0, 1);
            if (escalate) esc_seen = 1;
            checks++;
            if (dut_vec() !== mod_vec())
                $display("FAIL rain_cyc%0d got %h want %h", i, dut_vec(), mod_vec());
            else passed++;
        end
        step(3'b000, 0, 1);
`ifdef ANNUNC_RAIN_AUTOCLR_EN
        checks++;
        if (esc_seen) $display("FAIL rain_noesc got 1 want 0");
        else passed++;
        checks++;
        if (pending[0] !== 1'b0) $display("FAIL rain_autoclr got %b want 0", pending[0]);
        else passed++;
`else
        checks++;
        if (!esc_seen) $display("FAIL rain_esc got 0 want 1");
        else passed++;
        checks++;
        if (pending[0] !== 1'b1) $display("FAIL rain_held got %b want 1", pending[0]);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_fire();
        test_escalate();
        test_multi();
        test_overflow();
        test_reset_mid();
        test_rain();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
